// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ producers into one FIFO write port, one write per 3-cycle slot.
// Optional stall counter enabled by defining FIFO_WR_ARBITER_STALL_CNT_EN.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          write_en,
  output logic [DATA_WIDTH-1:0]         data_in,
`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
  output logic [15:0]                   stall_cnt,
`endif
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, SETTLE} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        last_gnt_reg;
  logic [IDX_W-1:0]        sel_idx;
  logic                    sel_valid;
  logic                    take;
  logic [NUM_REQ-1:0]      gnt_reg;
  logic                    write_en_reg;
  logic [DATA_WIDTH-1:0]   data_in_reg;
  logic [DATA_WIDTH-1:0]   words [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Scan offsets from farthest to nearest so the nearest requester after last_gnt wins.
  always_comb begin
    logic [IDX_W:0] cand;
    cand      = '0;
    sel_idx   = '0;
    sel_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, last_gnt_reg} + (IDX_W+1)'(k + 1);
      if (cand >= (IDX_W+1)'(NUM_REQ))
        cand = cand - (IDX_W+1)'(NUM_REQ);
      if (req[cand[IDX_W-1:0]]) begin
        sel_idx   = cand[IDX_W-1:0];
        sel_valid = 1'b1;
      end
    end
  end

  assign take = (state_reg == IDLE) && !fifo_full && sel_valid;

  always_ff @(posedge clock) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (take) state_next = GRANT;
      GRANT:   state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
  end

  // Grant, strobe and word are loaded at the selecting edge so they are registered outputs in GRANT.
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_reg      <= '0;
      write_en_reg <= 1'b0;
      data_in_reg  <= '0;
      last_gnt_reg <= IDX_W'(NUM_REQ - 1);
    end else begin
      write_en_reg <= take;
      gnt_reg      <= take ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx) : '0;
      if (take) begin
        data_in_reg  <= words[sel_idx];
        last_gnt_reg <= sel_idx;
      end
    end
  end

  assign gnt      = gnt_reg;
  assign write_en = write_en_reg;
  assign data_in  = data_in_reg;

`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset)
      stall_cnt_reg <= '0;
    else if ((state_reg == IDLE) && (|req) && fifo_full && (stall_cnt_reg != 16'hFFFF))
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized producers/FIFO against a slot-based reference model.
// Stall counter checks are active when FIFO_WR_ARBITER_STALL_CNT_EN is defined.
module tb_fifo_wr_arbiter;
  localparam int DW    = 8;
  localparam int NR    = 4;
  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic              fifo_full;
  logic [NR-1:0]     gnt;
  logic              write_en;
  logic [DW-1:0]     data_in;
  logic              busy;
`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  always #5 clock = ~clock;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .fifo_full(fifo_full), .gnt(gnt), .write_en(write_en), .data_in(data_in),
`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: after a write the arbiter is blind for two more edges.
  int            m_cool;
  int            m_last;
  logic [NR-1:0] m_gnt;
  logic          m_we;
  logic [DW-1:0] m_data;
  logic          m_busy;
  int            m_stall;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit found;
    if (reset) begin
      m_cool = 0; m_last = NR - 1; m_gnt = '0; m_we = 1'b0;
      m_data = '0; m_busy = 1'b0; m_stall = 0;
    end else if (m_cool == 0) begin
      m_gnt = '0; m_we = 1'b0; m_busy = 1'b0;
      if (req != '0 && !fifo_full) begin
        found = 1'b0;
        for (int k = 1; k <= NR; k++) begin
          int i;
          i = (m_last + k) % NR;
          if (!found && req[i]) begin
            found  = 1'b1;
            m_gnt  = NR'(1) << i;
            m_data = req_data[i*DW +: DW];
            m_last = i;
          end
        end
        m_we = 1'b1; m_busy = 1'b1; m_cool = 2;
      end else if (req != '0 && fifo_full && m_stall < 65535) begin
        m_stall++;
      end
    end else begin
      m_gnt = '0; m_we = 1'b0;
      m_cool--;
      m_busy = (m_cool != 0);
    end
  endtask

  // One clock: predict, advance, then compare every output against the model.
  task automatic tick();
    model_edge();
    @(posedge clock);
    #2;
    check_val("gnt", 32'(gnt), 32'(m_gnt));
    check_val("write_en", 32'(write_en), 32'(m_we));
    check_val("busy", 32'(busy), 32'(m_busy));
    if (m_we) check_val("data_in", 32'(data_in), 32'(m_data));
`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
    check_val("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    if (write_en) $display("write: gnt=%b data=%02h", gnt, data_in);
  endtask

  function automatic int gnt_index(input logic [NR-1:0] g);
    int r;
    r = -1;
    for (int k = 0; k < NR; k++) if (g[k]) r = k;
    return r;
  endfunction

  int            wr_cnt;
  logic [DW-1:0] wq[$];
  int            iq[$];
  logic [DW-1:0] exp_seq [5];
  int            rem [NR];
  int            seq [NR];
  int            fifo_cnt;
  int            gidx;
  int            cyc;
  bit            pending;

  initial begin
    reset = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
    tick(); tick();
    check_val("rst_gnt", 32'(gnt), 32'h0);
    check_val("rst_we", 32'(write_en), 32'h0);
    check_val("rst_data", 32'(data_in), 32'h0);

    // Single requester: one write every three cycles
    reset = 1'b0; req = 4'b0001; req_data = 32'h000000A5;
    tick();
    check_val("t1_gnt", 32'(gnt), 32'h1);
    check_val("t1_data", 32'(data_in), 32'hA5);
    wr_cnt = 1;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (write_en) wr_cnt++;
    end
    check_val("t1_rate", 32'(wr_cnt), 32'd3);
    req = '0;
    tick(); tick();

    // All four requesting: strict rotation 0,1,2,3,0
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1111; req_data = 32'h13121110;
    for (int t = 0; t < 20 && wq.size() < 5; t++) begin
      tick();
      if (write_en) begin wq.push_back(data_in); iq.push_back(gnt_index(gnt)); end
    end
    check_val("t2_count", 32'(wq.size()), 32'd5);
    exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    for (int k = 0; k < 5 && k < wq.size(); k++) begin
      check_val("t2_data", 32'(wq[k]), 32'(exp_seq[k]));
      check_val("t2_idx", 32'(iq[k]), 32'(k % 4));
    end
    req = '0;
    tick(); tick(); tick();

    // Park last grant on index 2, then 0 and 1 must follow via wrap-around
    req = 4'b0100;
    tick();
    check_val("t3_pre", 32'(gnt), 32'h4);
    req = '0;
    tick(); tick();
    req = 4'b0011; wq.delete(); iq.delete();
    for (int t = 0; t < 12 && iq.size() < 2; t++) begin
      tick();
      if (write_en) iq.push_back(gnt_index(gnt));
    end
    check_val("t3_count", 32'(iq.size()), 32'd2);
    if (iq.size() == 2) begin
      check_val("t3_first", 32'(iq[0]), 32'd0);
      check_val("t3_second", 32'(iq[1]), 32'd1);
    end
    req = '0;
    tick(); tick(); tick();

    // FIFO full blocks grants for ten cycles
    req = 4'b0100; fifo_full = 1'b1; wr_cnt = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (write_en || gnt != '0) wr_cnt++;
    end
    check_val("t4_blocked", 32'(wr_cnt), 32'd0);
`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
    check_val("t4_stall", 32'(stall_cnt), 32'd10);
`endif
    fifo_full = 1'b0;
    tick();
    check_val("t4_gnt", 32'(gnt), 32'h4);
    req = '0;
    tick(); tick(); tick();

    // Reset during GRANT aborts; next grant restarts from index 0
    req = 4'b1010;
    tick();
    check_val("t5_gnt", 32'(gnt), 32'h8);
    reset = 1'b1;
    tick();
    check_val("t5_abort_gnt", 32'(gnt), 32'h0);
    check_val("t5_abort_we", 32'(write_en), 32'h0);
    check_val("t5_abort_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick();
    check_val("t5_regrant", 32'(gnt), 32'h2);
    req = '0;
    tick(); tick(); tick();

    // Random producers feeding a DEPTH-entry FIFO with random drain
    reset = 1'b1; tick(); reset = 1'b0;
    fifo_cnt = 0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = int'($urandom_range(5, 15));
      seq[i] = 0;
    end
    cyc = 0;
    pending = 1'b1;
    while (pending && cyc < 3000) begin
      if (write_en) begin
        check_val("sb_room", 32'(fifo_cnt < DEPTH), 32'd1);
        gidx = gnt_index(gnt);
        check_val("sb_onehot", 32'($countones(gnt)), 32'd1);
        if (gidx >= 0) begin
          check_val("sb_data", 32'(data_in), 32'(gidx * 64 + seq[gidx]));
          seq[gidx]++;
          rem[gidx]--;
        end
        fifo_cnt++;
      end
      if (fifo_cnt > 0 && $urandom_range(0, 2) == 0) fifo_cnt--;
      pending = busy;
      for (int i = 0; i < NR; i++) begin
        req[i] = (rem[i] > 0);
        req_data[i*DW +: DW] = DW'(i * 64 + seq[i]);
        if (rem[i] > 0) pending = 1'b1;
      end
      fifo_full = (fifo_cnt >= DEPTH);
      tick();
      cyc++;
    end
    for (int i = 0; i < NR; i++) check_val("drain", 32'(rem[i]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each write word.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of producer ports (2..8).
REQ-003 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  NUM_REQ  per-producer write request, held until granted.
REQ-006 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  producer i word in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port gnt  output  NUM_REQ  one-hot grant pulse, registered.
REQ-008 SHALL have port write_en  output  1  FIFO write strobe, registered.
REQ-009 SHALL have port data_in  output  DATA_WIDTH  FIFO write word, registered.
REQ-010 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM with states IDLE, GRANT, SETTLE.
REQ-013 IDLE -> GRANT at a rising edge where fifo_full==0 and req!=0; otherwise remain in IDLE.
REQ-014 On IDLE->GRANT, SHALL select the first requesting index searching from (last_gnt+1) mod NUM_REQ upward with wrap-around (round-robin).
REQ-015 In GRANT, gnt SHALL be one-hot for the selected index, write_en=1, and data_in=req_data of that index captured at the selecting edge, all for exactly one cycle.
REQ-016 GRANT -> SETTLE unconditionally; SETTLE -> IDLE unconditionally. gnt=0 and write_en=0 in SETTLE and IDLE.
REQ-017 last_gnt SHALL update to the selected index on IDLE->GRANT only.
REQ-018 Minimum spacing between writes SHALL be 3 cycles (IDLE, GRANT, SETTLE), so fifo_full always reflects the prior write before the next selection.
REQ-019 Producer protocol: on seeing gnt[i]=1, producer i SHALL deassert req[i] or present its next word by the end of the SETTLE cycle; the arbiter never samples req during GRANT or SETTLE.
REQ-020 If fifo_full==1 in IDLE, SHALL issue no grant, leave last_gnt unchanged, and keep requests pending.
REQ-021 Single active requester SHALL be granted repeatedly, once per 3-cycle slot.
REQ-022 Requests asserted or withdrawn during GRANT/SETTLE SHALL take effect at the next IDLE evaluation only.
REQ-023 fifo_full asserting during GRANT SHALL NOT cancel the write already in flight.

Reset
REQ-024 While reset==1 at a rising edge: state=IDLE, gnt=0, write_en=0, data_in=0, busy=0, last_gnt=NUM_REQ-1 (index 0 has first priority).
REQ-025 Reset asserted in GRANT or SETTLE SHALL abort immediately; the aborted grant is not retried, and the producer keeps req high.
REQ-026 First selection after reset release SHALL occur no earlier than the first edge with reset==0.

Configuration
REQ-027 Macro FIFO_WR_ARBITER_STALL_CNT_EN, when defined, SHALL add output stall_cnt (16 bits): it increments by 1 each cycle in IDLE with req!=0 and fifo_full==1, saturates at 16'hFFFF, and clears on reset.
REQ-028 Without FIFO_WR_ARBITER_STALL_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then req=4'b0001 with data 8'hA5, fifo_full=0 -> gnt=4'b0001, write_en=1, data_in=8'hA5 in the cycle after the selecting edge; one write every 3 cycles while req is held.
REQ-030 req=4'b1111 held, data i=8'h10+i -> write sequence 8'h10, 8'h11, 8'h12, 8'h13, 8'h10, and so on, with gnt order 0,1,2,3,0.
REQ-031 last_gnt=2, req=4'b0011 -> index 0 granted next, then index 1 (wrap-around).
REQ-032 fifo_full=1 for 10 cycles with req=4'b0100 -> no write_en, gnt stays 0, and stall_cnt=10 when the macro is defined; fifo_full drops -> index 2 granted at the next IDLE edge.
REQ-033 Reset asserted in the GRANT cycle -> next cycle all outputs 0 and state IDLE; the next grant goes to the lowest requesting index.
REQ-034 Connected to the team fifo with DEPTH writes pending from 4 producers -> no write_en while fifo_full==1 and no lost or duplicated words (scoreboard compares per-producer order).
